// File: rtl/timer_irq_pkg.sv
// Shared constants for the memory-mapped interval timer: register window base,
// register offsets within the window and TCON bit positions.
package timer_irq_pkg;

  localparam logic [31:0] TIMER_BASE = 32'h4000_0000;

  localparam logic [1:0] TH_OFS   = 2'd0;
  localparam logic [1:0] TL_OFS   = 2'd1;
  localparam logic [1:0] TCON_OFS = 2'd2;

  localparam int EN_BIT = 0;
  localparam int IE_BIT = 1;
  localparam int ST_BIT = 2;
  localparam int OS_BIT = 3;

  // Window match on the upper address bits; the window is 16-byte aligned.
  function automatic logic addr_hit(input logic [27:0] addr_hi,
                                    input logic [27:0] base_hi);
    return addr_hi == base_hi;
  endfunction

endpackage

// File: rtl/timer_irq_if.sv
// MEM-stage data bus seen by the timer: load/store strobes, address, data.
interface timer_irq_if;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemRd, output MemWr, output Addr, output WriteData,
                  input  ReadData);
  modport slave  (input  MemRd, input  MemWr, input  Addr, input  WriteData,
                  output ReadData);
endinterface

// File: rtl/timer_irq_prescaler.sv
// Clock prescaler: emits one tick every PRESCALE enabled cycles; the count is
// held at zero whenever the timer is (or is about to become) disabled.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic en_next,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] pcnt;
  logic [15:0] pcnt_next;

  // A disable written this cycle clears the count at the same edge.
  always_comb begin
    pcnt_next = '0;
    if (en && en_next && (pcnt != LAST))
      pcnt_next = pcnt + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pcnt <= '0;
    else
      pcnt <= pcnt_next;
  end

  assign tick = en && (pcnt == LAST);

endmodule

// File: rtl/timer_irq.sv
// Memory-mapped interval timer with level IRQ (TH reload, TL up-counter, TCON).
// Optional one-shot mode (TCON.OS) is built when TIMER_ONESHOT_EN is defined.
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TIMER_BASE,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  timer_irq_if.slave  bus,
  output logic        IRQ
);

  logic [31:0] th, th_next;
  logic [31:0] tl, tl_next;
  logic        en, en_next;
  logic        ie, ie_next;
  logic        st, st_next;
  logic        os;
  logic        hit, wr, rd, tick, ovf;
  logic [1:0]  ofs;
  logic [31:0] tcon, rdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.Addr[1:0];

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .en_next (en_next),
    .tick    (tick)
  );

  always_comb begin
    hit  = addr_hit(bus.Addr[31:4], BASE_ADDR[31:4]);
    ofs  = bus.Addr[3:2];
    wr   = bus.MemWr && hit;
    rd   = bus.MemRd && hit;
    tcon = {28'd0, os, st, ie, en};
    ovf  = tick && (tl == 32'hFFFF_FFFF);

    rdata = 32'h0;
    if (rd) begin
      case (ofs)
        TH_OFS:   rdata = th;
        TL_OFS:   rdata = tl;
        TCON_OFS: rdata = tcon;
        default:  rdata = 32'h0;
      endcase
    end

    th_next = th;
    tl_next = tl;
    en_next = en;
    ie_next = ie;
    st_next = st;

    if (wr && (ofs == TH_OFS))
      th_next = bus.WriteData;

    // Bus write to TL beats both the increment and the reload.
    if (wr && (ofs == TL_OFS))
      tl_next = bus.WriteData;
    else if (ovf)
      tl_next = th;
    else if (tick)
      tl_next = tl + 32'd1;

`ifdef TIMER_ONESHOT_EN
    if (ovf && os)
      en_next = 1'b0;
`endif

    if (wr && (ofs == TCON_OFS)) begin
      en_next = bus.WriteData[EN_BIT];
      ie_next = bus.WriteData[IE_BIT];
      st_next = bus.WriteData[ST_BIT];
    end

    // Overflow set wins over a software clear so no interrupt is lost.
    if (ovf)
      st_next = 1'b1;
  end

  assign bus.ReadData = rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th  <= '0;
      tl  <= '0;
      en  <= 1'b0;
      ie  <= 1'b0;
      st  <= 1'b0;
      IRQ <= 1'b0;
    end else begin
      th  <= th_next;
      tl  <= tl_next;
      en  <= en_next;
      ie  <= ie_next;
      st  <= st_next;
      IRQ <= ie & st;
    end
  end

`ifdef TIMER_ONESHOT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      os <= 1'b0;
    else if (wr && (ofs == TCON_OFS))
      os <= bus.WriteData[OS_BIT];
  end
`else
  assign os = 1'b0;
`endif

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: two instances (PRESCALE=1 and PRESCALE=4)
// with load results checked through an expected-value queue.
module tb_timer_irq;
  import timer_irq_pkg::*;

  localparam logic [31:0] A_TH   = TIMER_BASE + 32'h0;
  localparam logic [31:0] A_TL   = TIMER_BASE + 32'h4;
  localparam logic [31:0] A_TCON = TIMER_BASE + 32'h8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq1, irq4;
  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  timer_irq_if bus1 ();
  timer_irq_if bus4 ();

  timer_irq #(.BASE_ADDR(TIMER_BASE), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .IRQ(irq1));
  timer_irq #(.BASE_ADDR(TIMER_BASE), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave), .IRQ(irq4));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (s) begin
      bus4.MemRd = r; bus4.MemWr = w; bus4.Addr = a; bus4.WriteData = d;
    end else begin
      bus1.MemRd = r; bus1.MemWr = w; bus1.Addr = a; bus1.WriteData = d;
    end
  endtask

  task automatic bus_wr(input bit s, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(s, 1'b0, 1'b1, a, d);
    @(negedge clk);
    drive(s, 1'b0, 1'b0, a, 32'h0);
  endtask

  // Read at the current time (caller is just past a negedge).
  task automatic rd_now(input bit s, input logic [31:0] a, input logic [31:0] exp,
                        input string tag);
    logic [31:0] obs;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    drive(s, 1'b1, 1'b0, a, 32'h0);
    #1;
    obs = s ? bus4.ReadData : bus1.ReadData;
    drive(s, 1'b0, 1'b0, a, 32'h0);
    check(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic bus_rd(input bit s, input logic [31:0] a, input logic [31:0] exp,
                        input string tag);
    @(negedge clk);
    rd_now(s, a, exp, tag);
  endtask

  task automatic irq_chk(input bit s, input logic exp, input string tag);
    check(tag, {31'd0, s ? irq4 : irq1}, {31'd0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Power-on reset state
    @(negedge clk);
    irq_chk(0, 1'b0, "por_irq1");
    irq_chk(1, 1'b0, "por_irq4");
    rd_now(0, A_TCON, 32'h0, "por_tcon");
    reset = 1'b0;

    // Asynchronous reset mid-count with TCON=7, TL=5
    bus_wr(0, A_TL, 32'h5);
    bus_wr(0, A_TCON, 32'h7);
    idle(1);
    irq_chk(0, 1'b1, "pre_rst_irq");
    #2 reset = 1'b1;
    #1 irq_chk(0, 1'b0, "async_rst_irq");
    rd_now(0, A_TH, 32'h0, "rst_th");
    rd_now(0, A_TL, 32'h0, "rst_tl");
    rd_now(0, A_TCON, 32'h0, "rst_tcon");
    @(negedge clk);
    reset = 1'b0;

    // MemRd low gives zero even on a hit address
    drive(0, 1'b0, 1'b0, A_TL, 32'h0);
    #1 check("rd_low", bus1.ReadData, 32'h0);

    // Reload period with PRESCALE=1
    bus_wr(0, A_TH, 32'hFFFF_FFFC);
    bus_wr(0, A_TL, 32'hFFFF_FFFC);
    bus_wr(0, A_TCON, 32'h3);
    for (int k = 1; k <= 5; k++) begin
      bus_rd(0, A_TCON, (k >= 4) ? 32'h7 : 32'h3, $sformatf("reload_tcon_%0d", k));
      irq_chk(0, k == 5, $sformatf("reload_irq_%0d", k));
    end
    bus_rd(0, A_TL, 32'hFFFF_FFFE, "reload_tl");

    // Ack lands on the next overflow edge: set wins
    bus_wr(0, A_TCON, 32'h3);
    irq_chk(0, 1'b1, "coll_irq_a");
    bus_rd(0, A_TCON, 32'h7, "coll_tcon");
    irq_chk(0, 1'b1, "coll_irq_b");
    bus_rd(0, A_TL, 32'hFFFF_FFFE, "period2_tl");

    // Ordinary acknowledge
    idle(1);
    bus_wr(0, A_TCON, 32'h3);
    irq_chk(0, 1'b1, "ack_irq_edge");
    bus_rd(0, A_TCON, 32'h3, "ack_tcon");
    irq_chk(0, 1'b0, "ack_irq_next");

    // Disable on an overflow edge: ST still set, IE=0 masks IRQ
    bus_wr(0, A_TCON, 32'h0);
    irq_chk(0, 1'b0, "mask_irq_a");
    bus_rd(0, A_TCON, 32'h4, "mask_tcon");
    irq_chk(0, 1'b0, "mask_irq_b");
    bus_wr(0, A_TCON, 32'h6);
    irq_chk(0, 1'b0, "unmask_irq_edge");
    idle(1);
    irq_chk(0, 1'b1, "unmask_irq_next");
    bus_wr(0, A_TCON, 32'h2);
    irq_chk(0, 1'b1, "ack2_irq_edge");
    idle(1);
    irq_chk(0, 1'b0, "ack2_irq_next");
    bus_rd(0, A_TL, 32'hFFFF_FFFC, "frozen_tl");

    // Address decode
    bus_rd(0, TIMER_BASE + 32'hC, 32'h0, "rsvd_rd");
    bus_rd(0, TIMER_BASE + 32'h10, 32'h0, "miss_rd");
    bus_wr(0, TIMER_BASE + 32'h10, 32'hDEAD_BEEF);
    bus_wr(0, TIMER_BASE + 32'hC, 32'hDEAD_BEEF);
    bus_rd(0, A_TH, 32'hFFFF_FFFC, "miss_wr_th");
    bus_rd(0, TIMER_BASE + 32'h5, 32'hFFFF_FFFC, "byte_ofs_tl");
    bus_rd(0, A_TCON, 32'h2, "miss_wr_tcon");

    // TL write on a tick edge wins over the increment
    bus_wr(0, A_TCON, 32'h1);
    bus_wr(0, A_TL, 32'h10);
    rd_now(0, A_TL, 32'h10, "tl_wr_tick");
    bus_rd(0, A_TL, 32'h11, "tl_after_wr");

`ifdef TIMER_ONESHOT_EN
    bus_wr(0, A_TCON, 32'h0);
    bus_wr(0, A_TH, 32'h100);
    bus_wr(0, A_TL, 32'hFFFF_FFFF);
    bus_wr(0, A_TCON, 32'hB);
    bus_rd(0, A_TCON, 32'hE, "os_tcon");
    bus_rd(0, A_TL, 32'h100, "os_tl_a");
    irq_chk(0, 1'b1, "os_irq");
    bus_rd(0, A_TL, 32'h100, "os_tl_hold");
`else
    bus_wr(0, A_TCON, 32'h8);
    bus_rd(0, A_TCON, 32'h0, "os_absent");
`endif

    // PRESCALE=4 instance
    bus_wr(1, A_TCON, 32'h1);
    idle(2);
    bus_rd(1, A_TL, 32'h0, "ps_tl_3");
    bus_rd(1, A_TL, 32'h1, "ps_tl_4");
    idle(7);
    bus_rd(1, A_TL, 32'h3, "ps_tl_12");
    bus_wr(1, A_TCON, 32'h0);
    idle(6);
    bus_rd(1, A_TL, 32'h3, "ps_frozen");
    bus_wr(1, A_TCON, 32'h1);
    idle(2);
    bus_rd(1, A_TL, 32'h3, "ps_restart_3");
    bus_rd(1, A_TL, 32'h4, "ps_restart_4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
